// File: rtl/kme_ib_tlv_framer.sv
// ===========================================================================
// kme_ib_tlv_framer: inbound TLV framer, 2-entry skid buffer, tlast generation
// Revision: 1.0
// ===========================================================================
`default_nettype none

module kme_ib_tlv_framer #(
  parameter int TID_W         = 1,
  parameter int MEGA_TYPE_MIN = 21,
  parameter int GUID_TYPE     = 10,
  parameter int GUID_FLAG_BIT = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [63:0]      s_tdata,
  input  logic [7:0]       s_tstrb,
  input  logic [7:0]       s_tuser,
  input  logic [TID_W-1:0] s_tid,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [63:0]      m_tdata,
  output logic [7:0]       m_tstrb,
  output logic [7:0]       m_tuser,
  output logic [TID_W-1:0] m_tid,
  output logic             m_tlast,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cmd_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             proto_err
);

  localparam logic [7:0] MEGA_MIN_B = 8'(MEGA_TYPE_MIN);
  localparam logic [7:0] GUID_B     = 8'(GUID_TYPE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    IN_TLV    = 3'd1,
    IN_MEGA   = 3'd2,
    GUID_PEND = 3'd3,
    IN_GUID   = 3'd4
  } state_t;

  state_t     state, nxt_state;
  logic       guid_flag, nxt_flag;
  logic [2:0] wcnt, nxt_wcnt;
  logic       word_last, word_err;
  logic       sot, eot, bad_user, is_mega, is_guid, mflag;
  logic       accept, pop;

  logic [63:0]      mem_data [2];
  logic [7:0]       mem_strb [2];
  logic [7:0]       mem_user [2];
  logic [TID_W-1:0] mem_tid  [2];
  logic [1:0]       mem_last;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, count_nxt;

  assign accept = s_tvalid && s_tready;
  assign pop    = (count != 2'd0) && m_tready;

  assign sot      = (s_tuser == 8'h01) || (s_tuser == 8'h03);
  assign eot      = (s_tuser == 8'h02) || (s_tuser == 8'h03);
  assign bad_user = (s_tuser > 8'h03);
  assign is_mega  = (s_tdata[7:0] >= MEGA_MIN_B);
  assign is_guid  = (s_tdata[7:0] == GUID_B);

  // Framing decision for the word currently presented; committed only on accept.
  always_comb begin
    nxt_state = state;
    nxt_flag  = guid_flag;
    nxt_wcnt  = wcnt;
    word_last = 1'b0;
    word_err  = 1'b0;
    mflag     = guid_flag;
    if (sot) begin
      if (state != IDLE && !(state == GUID_PEND && is_guid))
        word_err = 1'b1;
      if (state == GUID_PEND && is_guid) begin
        nxt_state = eot ? IDLE : IN_GUID;
        word_last = eot;
      end else if (is_mega) begin
        nxt_flag  = 1'b0;
        nxt_wcnt  = 3'd1;
        nxt_state = eot ? IDLE : IN_MEGA;
        word_last = eot;
      end else begin
        nxt_state = eot ? IDLE : IN_TLV;
      end
    end else begin
      word_err = bad_user;
      case (state)
        IDLE, GUID_PEND: word_err = 1'b1;
        IN_MEGA: begin
          if (wcnt != 3'd7)
            nxt_wcnt = wcnt + 3'd1;
          // The second word carries the GUID flag, and may also be the EoT.
          mflag    = (wcnt == 3'd1) ? s_tdata[GUID_FLAG_BIT] : guid_flag;
          nxt_flag = mflag;
          if (eot) begin
            word_last = !mflag;
            nxt_state = mflag ? GUID_PEND : IDLE;
          end
        end
        IN_GUID: begin
          if (eot) begin
            word_last = 1'b1;
            nxt_state = IDLE;
          end
        end
        IN_TLV: begin
          if (eot)
            nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      guid_flag <= 1'b0;
      wcnt      <= 3'd0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= accept && word_err;
      if (accept) begin
        state     <= nxt_state;
        guid_flag <= nxt_flag;
        wcnt      <= nxt_wcnt;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (accept && !pop)
      count_nxt = count + 2'd1;
    else if (!accept && pop)
      count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data[i] <= '0;
        mem_strb[i] <= '0;
        mem_user[i] <= '0;
        mem_tid[i]  <= '0;
      end
      mem_last <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      s_tready <= 1'b0;
    end else begin
      if (accept) begin
        mem_data[wr_ptr] <= s_tdata;
        mem_strb[wr_ptr] <= s_tstrb;
        mem_user[wr_ptr] <= s_tuser;
        mem_tid[wr_ptr]  <= s_tid;
        mem_last[wr_ptr] <= word_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      s_tready <= (count_nxt < 2'd2);
    end
  end

  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = mem_data[rd_ptr];
  assign m_tstrb  = mem_strb[rd_ptr];
  assign m_tuser  = mem_user[rd_ptr];
  assign m_tid    = mem_tid[rd_ptr];
  assign m_tlast  = m_tvalid && mem_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_cnt <= '0;
      err_cnt <= '0;
    end else if (clr_cnt) begin
      cmd_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (m_tvalid && m_tready && m_tlast && (cmd_cnt != {CNT_W{1'b1}}))
        cmd_cnt <= cmd_cnt + 1'b1;
      if (accept && word_err && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kme_ib_tlv_framer.sv
// ===========================================================================
// tb_kme_ib_tlv_framer: directed stimulus with queue scoreboard and monitor
// Revision: 1.0
// ===========================================================================
`default_nettype none

module tb_kme_ib_tlv_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid, s_tready;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb, s_tuser;
  logic [0:0]  s_tid;
  logic        m_tvalid, m_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tstrb, m_tuser;
  logic [0:0]  m_tid;
  logic        m_tlast;
  logic        clr_cnt;
  logic [15:0] cmd_cnt, err_cnt;
  logic        proto_err;

  always #5 clk = ~clk;

  kme_ib_tlv_framer dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tstrb(s_tstrb), .s_tuser(s_tuser), .s_tid(s_tid),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tstrb(m_tstrb), .m_tuser(m_tuser), .m_tid(m_tid), .m_tlast(m_tlast),
    .clr_cnt(clr_cnt), .cmd_cnt(cmd_cnt), .err_cnt(err_cnt), .proto_err(proto_err)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [81:0] sbq[$];
  int          tlast_seen = 0;
  logic        tid_tog = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] held_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every downstream transfer against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else if (m_tvalid) begin
      if (prev_stall)
        check("stall_hold", m_tdata, held_data);
      if (!m_tready) begin
        prev_stall = 1'b1;
        held_data  = m_tdata;
      end else begin
        prev_stall = 1'b0;
        if (sbq.size() == 0) begin
          check("unexpected_word", m_tvalid, 1'b0);
        end else begin
          logic [81:0] exp_word;
          exp_word = sbq.pop_front();
          check("out_word", {m_tdata, m_tstrb, m_tuser, m_tid, m_tlast}, exp_word);
          if (m_tlast) tlast_seen++;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [63:0] d, input logic [7:0] u, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tstrb  = 8'hFF;
    s_tid    = tid_tog;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready)
      check("send_timeout", s_tready, 1'b1);
    else
      sbq.push_back({d, 8'hFF, u, tid_tog, l});
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    tid_tog  = ~tid_tog;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || m_tvalid) && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain_empty", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
    s_tid = '0; m_tready = 1'b1; clr_cnt = 1'b0;
    #2;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tdata", m_tdata, 64'h0);
    check("rst_cnts", {cmd_cnt, err_cnt, proto_err}, 33'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_tready_after_rst", s_tready, 1'b1);

    // Mega 0x15, 4 words, no GUID
    send(64'hA100_0000_0000_0015, 8'h01, 1'b0);
    check("latency_valid", m_tvalid, 1'b1);
    check("latency_data", m_tdata, 64'hA100_0000_0000_0015);
    send(64'hA200_0000_0000_0002, 8'h00, 1'b0);
    send(64'hA300_0000_0000_0003, 8'h00, 1'b0);
    send(64'hA400_0000_0000_0004, 8'h02, 1'b1);
    drain();
    check("t1_cmd_cnt", cmd_cnt, 16'd1);

    // Mega 0x16 with GUID flag, then GUID TLV of 3 words
    send(64'hB100_0000_0000_0016, 8'h01, 1'b0);
    send(64'hB200_0000_0000_0010, 8'h00, 1'b0);
    send(64'hB300_0000_0000_0003, 8'h02, 1'b0);
    send(64'hC100_0000_0000_000A, 8'h01, 1'b0);
    send(64'hC200_0000_0000_0002, 8'h00, 1'b0);
    send(64'hC300_0000_0000_0003, 8'h02, 1'b1);
    drain();
    check("t2_cmd_cnt", cmd_cnt, 16'd2);

    // Ordinary TLV then mega without GUID
    send(64'hD100_0000_0000_0001, 8'h01, 1'b0);
    send(64'hD200_0000_0000_0002, 8'h02, 1'b0);
    send(64'hD300_0000_0000_0015, 8'h01, 1'b0);
    send(64'hD400_0000_0000_0000, 8'h00, 1'b0);
    send(64'hD500_0000_0000_0005, 8'h02, 1'b1);
    drain();
    check("t3_cmd_cnt", cmd_cnt, 16'd3);
    check("t3_err_cnt", err_cnt, 16'd0);

    // Back-pressure during a 6-word mega burst
    m_tready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_s_tready_low", s_tready, 1'b0);
        repeat (2) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join_none
    send(64'hE100_0000_0000_0017, 8'h01, 1'b0);
    send(64'hE200_0000_0000_0000, 8'h00, 1'b0);
    send(64'hE300_0000_0000_0003, 8'h00, 1'b0);
    send(64'hE400_0000_0000_0004, 8'h00, 1'b0);
    send(64'hE500_0000_0000_0005, 8'h00, 1'b0);
    send(64'hE600_0000_0000_0006, 8'h02, 1'b1);
    drain();
    check("t4_cmd_cnt", cmd_cnt, 16'd4);

    // SoT mid-mega abandons the open TLV; new mega frames normally
    send(64'hF100_0000_0000_0015, 8'h01, 1'b0);
    send(64'hF200_0000_0000_0000, 8'h00, 1'b0);
    send(64'hF300_0000_0000_0015, 8'h01, 1'b0);
    check("sot_mid_pulse", proto_err, 1'b1);
    send(64'hF400_0000_0000_0000, 8'h00, 1'b0);
    check("pulse_one_cycle", proto_err, 1'b0);
    send(64'hF500_0000_0000_0005, 8'h02, 1'b1);
    drain();
    check("t5_err_cnt", err_cnt, 16'd1);
    send(64'h5500_0000_0000_0055, 8'h02, 1'b0);
    check("eot_idle_pulse", proto_err, 1'b1);
    drain();
    check("t5b_err_cnt", err_cnt, 16'd2);
    send(64'h7700_0000_0000_0077, 8'h05, 1'b0);
    // Non-GUID SoT while GUID pending: error, then single-word mega
    send(64'h8100_0000_0000_0015, 8'h01, 1'b0);
    send(64'h8200_0000_0000_0010, 8'h00, 1'b0);
    send(64'h8300_0000_0000_0003, 8'h02, 1'b0);
    send(64'h8400_0000_0000_0015, 8'h03, 1'b1);
    // Flag arriving on the EoT word of a 2-word mega, single-word GUID
    send(64'h9100_0000_0000_0015, 8'h01, 1'b0);
    send(64'h9200_0000_0000_0010, 8'h02, 1'b0);
    send(64'h9300_0000_0000_000A, 8'h03, 1'b1);
    drain();
    check("t5c_cmd_cnt", cmd_cnt, 16'd7);
    check("t5c_err_cnt", err_cnt, 16'd4);

    // Reset mid-mega with 2 words buffered
    m_tready = 1'b0;
    send(64'hAA00_0000_0000_0015, 8'h01, 1'b0);
    send(64'hAB00_0000_0000_0000, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", m_tvalid, 1'b0);
    check("rst_mid_cnts", {cmd_cnt, err_cnt}, 32'h0);
    sbq.delete();
    tlast_seen = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_tready = 1'b1;
    send(64'hAC00_0000_0000_0015, 8'h01, 1'b0);
    send(64'hAD00_0000_0000_0000, 8'h00, 1'b0);
    send(64'hAE00_0000_0000_0003, 8'h02, 1'b1);
    drain();
    check("post_rst_tlasts", tlast_seen, 1);
    check("post_rst_cmd_cnt", cmd_cnt, 16'd1);

    // clr_cnt coinciding with a tlast transfer
    m_tready = 1'b0;
    send(64'hBB00_0000_0000_0015, 8'h03, 1'b1);
    m_tready = 1'b1;
    clr_cnt  = 1'b1;
    @(posedge clk);
    #1 clr_cnt = 1'b0;
    check("clr_priority", cmd_cnt, 16'd0);
    drain();
    check("final_queue", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
